ov_capture_ctrl: RTL and testbench
==================================

OV_CAPTURE_CTRL -- requirements
Module: ov_capture_ctrl

Interface
REQ-001 SHALL have parameter VSYNC_TIMEOUT, default 24'd2_400_000 (100 ms at 24 MHz): maximum number of cycles to wait for a VSYNC edge.
REQ-002 SHALL have port clk_24MHz  input  1  system clock.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port initialized  input  1  camera SCCB configuration complete.
REQ-005 SHALL have port vsync  input  1  raw camera VSYNC, asynchronous, high pulse at each frame boundary.
REQ-006 SHALL have port capture_req  input  1  single-cycle request for one frame capture.
REQ-007 SHALL have port continuous  input  1  level; while high, captures repeat back-to-back.
REQ-008 SHALL have port frame_read  input  1  from the FIFO reader; high = reader idle, low = readout in progress.
REQ-009 SHALL have port new_frame  output  1  to the FIFO reader; a complete frame is in the FIFO.
REQ-010 SHALL have port fifo_wen  output  1  FIFO write enable, active-high.
REQ-011 SHALL have port fifo_wrst_n  output  1  FIFO write-pointer reset, active-low.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port timeout_err  output  1  sticky VSYNC-timeout flag.
REQ-014 SHALL have port frames_captured  output  8  count of completed frame writes.

Function
REQ-015 SHALL synchronise vsync through 2 flops, then detect edges; the decision SHALL occur 3 cycles after the raw edge.
REQ-016 SHALL implement states IDLE, ARM, WRST, WRITE, HANDOFF and READING, all registered.
REQ-017 IDLE -> ARM SHALL occur when initialized=1, frame_read=1, and (capture_req, pending or continuous)=1; this transition SHALL clear pending and timeout_err.
REQ-018 ARM SHALL drive all outputs inactive; on a vsync rising edge it SHALL move to WRST.
REQ-019 WRST SHALL hold fifo_wrst_n=0; on a vsync falling edge it SHALL move to WRITE.
REQ-020 WRITE SHALL set fifo_wrst_n=1 and fifo_wen=1; on the next vsync rising edge it SHALL clear fifo_wen in the same cycle, increment frames_captured (modulo 256, 255->0) and move to HANDOFF.
REQ-021 HANDOFF SHALL hold new_frame=1 until frame_read=0, then clear new_frame and move to READING; HANDOFF SHALL have no timeout.
REQ-022 READING SHALL wait for frame_read=1, then return to IDLE; re-arming the next cycle is allowed if continuous or pending is set.
REQ-023 A capture_req arriving while busy=1 SHALL set a one-deep pending flag; further requests SHALL be dropped.
REQ-024 A separate counter SHALL reload on entry to ARM, WRST and WRITE and on every vsync edge.
REQ-025 When that counter reaches VSYNC_TIMEOUT in ARM, WRST or WRITE, the block SHALL set timeout_err=1, deassert fifo_wen, set fifo_wrst_n=1, go to IDLE, and not count the frame.
REQ-026 If initialized falls in any state, the block SHALL abort to IDLE next cycle with new_frame=0, fifo_wen=0 and fifo_wrst_n=1; frames_captured SHALL be kept.
REQ-027 fifo_wen and fifo_wrst_n=0 SHALL never both be active; fifo_wen SHALL never be 1 while frame_read=0.
REQ-028 When capture_req and the abort condition occur in the same cycle, the abort SHALL win and the request SHALL be latched as pending.

Reset
REQ-029 While rst_n=0, the block SHALL hold state=IDLE, new_frame=0, fifo_wen=0, fifo_wrst_n=1, busy=0, timeout_err=0, frames_captured=0, pending=0, the synchroniser flops at 0, and the timeout counter at 0.
REQ-030 Reset assertion mid-write SHALL deassert fifo_wen asynchronously.

Structure
REQ-031 Shared package ov_pkg SHALL hold the state enum, the VSYNC_TIMEOUT default, and frame geometry constants (320x240x2 = 153600 bytes).
REQ-032 Sub-module ov_sync_edge SHALL contain the 2-flop synchroniser and rise/fall edge pulses; it SHALL be instantiated once.

Verification (bench uses VSYNC_TIMEOUT=1000, VSYNC period 800 cycles, pulse width 20)
REQ-033 Single capture: capture_req, then vsync pulses, reader model drops frame_read 2 cycles after new_frame -> wrst_n low for 20 cycles, wen high for 780 cycles, frames_captured=1, IDLE after frame_read returns high.
REQ-034 Continuous mode: continuous=1 for 3 frames, reader holds frame_read low 50 cycles -> frames_captured=3; wen never high while frame_read=0.
REQ-035 Timeout: capture_req with vsync stuck low -> timeout_err=1 after 1000 cycles in ARM, busy=0, frames_captured unchanged; next capture_req clears timeout_err.
REQ-036 Pending: second capture_req during WRITE, third during HANDOFF -> exactly 2 frames captured, third request dropped.
REQ-037 Abort: initialized dropped mid-WRITE -> next cycle wen=0, state IDLE, frames_captured unchanged; rst_n pulse mid-WRITE -> wen=0 with no clock edge.
REQ-038 Counter wrap: 256 captures -> frames_captured returns to 0.

Source files
------------

// File: rtl/ov_pkg.sv
// ov_pkg: shared state encoding, timeout default and frame geometry for the OV capture path
package ov_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WRST,
        S_WRITE,
        S_HANDOFF,
        S_READING
    } state_t;

    localparam logic [23:0] VSYNC_TIMEOUT_DEF = 24'd2_400_000;
    localparam int          FRAME_W           = 320;
    localparam int          FRAME_H           = 240;
    localparam int          BYTES_PER_PIX     = 2;
    localparam int          FRAME_BYTES       = FRAME_W * FRAME_H * BYTES_PER_PIX;

endpackage

// File: rtl/ov_sync_edge.sv
// ov_sync_edge: 2-flop synchroniser for the raw VSYNC with single-cycle rise/fall pulses
module ov_sync_edge (
    input  logic clk_24MHz,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk_24MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ov_capture_ctrl.sv
// ov_capture_ctrl: sequences one VSYNC-framed FIFO write per capture request and hands it to the reader
module ov_capture_ctrl
    import ov_pkg::*;
#(
    parameter logic [23:0] VSYNC_TIMEOUT = VSYNC_TIMEOUT_DEF
) (
    input  logic       clk_24MHz,
    input  logic       rst_n,
    input  logic       initialized,
    input  logic       vsync,
    input  logic       capture_req,
    input  logic       continuous,
    input  logic       frame_read,
    output logic       new_frame,
    output logic       fifo_wen,
    output logic       fifo_wrst_n,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] frames_captured
);

    state_t      r_state;
    state_t      w_next;
    logic        w_rise;
    logic        w_fall;
    logic        w_go;
    logic        w_timed;
    logic        w_next_timed;
    logic        w_expire;
    logic        w_reload;
    logic        r_pending;
    logic        r_timeout;
    logic [7:0]  r_frames;
    logic [23:0] r_cnt;

    ov_sync_edge u_sync (
        .clk_24MHz (clk_24MHz),
        .rst_n     (rst_n),
        .i_async   (vsync),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    assign w_timed      = r_state inside {S_ARM, S_WRST, S_WRITE};
    assign w_next_timed = w_next inside {S_ARM, S_WRST, S_WRITE};
    assign w_expire     = w_timed && (r_cnt >= VSYNC_TIMEOUT);
    assign w_go         = (r_state == S_IDLE) && initialized && frame_read &&
                          (capture_req || r_pending || continuous);
    assign w_reload     = (w_next != r_state) || w_rise || w_fall;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = w_go ? S_ARM : S_IDLE;
            S_ARM:     w_next = w_rise ? S_WRST : S_ARM;
            S_WRST:    w_next = w_fall ? S_WRITE : S_WRST;
            S_WRITE:   w_next = w_rise ? S_HANDOFF : S_WRITE;
            S_HANDOFF: w_next = frame_read ? S_HANDOFF : S_READING;
            S_READING: w_next = frame_read ? S_IDLE : S_READING;
            default:   w_next = S_IDLE;
        endcase
        if (!initialized || w_expire) w_next = S_IDLE;
        // outputs decode state only, so an async reset drops fifo_wen immediately
        new_frame       = r_state == S_HANDOFF;
        fifo_wen        = (r_state == S_WRITE) && frame_read;
        fifo_wrst_n     = r_state != S_WRST;
        busy            = r_state != S_IDLE;
        timeout_err     = r_timeout;
        frames_captured = r_frames;
    end

    always_ff @(posedge clk_24MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_timeout <= 1'b0;
            r_frames  <= 8'd0;
            r_cnt     <= 24'd0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_go ? 1'b0 : (capture_req | r_pending);
            r_timeout <= w_go ? 1'b0 : (r_timeout | (w_expire & initialized));
            if ((r_state == S_WRITE) && (w_next == S_HANDOFF)) r_frames <= r_frames + 8'd1;
            // counts cycles since the last state entry or vsync edge, starting at 1
            r_cnt     <= !w_next_timed ? 24'd0 : w_reload ? 24'd1 : r_cnt + 24'd1;
        end
    end

endmodule

// File: tb/tb_ov_capture_ctrl.sv
// tb_ov_capture_ctrl: scoreboard bench; stimulus queues expected frames, a monitor checks each new_frame
module tb_ov_capture_ctrl;

    logic       clk_24MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       initialized = 1'b0;
    logic       vsync = 1'b0;
    logic       capture_req = 1'b0;
    logic       continuous = 1'b0;
    logic       frame_read = 1'b1;
    logic       new_frame;
    logic       fifo_wen;
    logic       fifo_wrst_n;
    logic       busy;
    logic       timeout_err;
    logic [7:0] frames_captured;

    typedef struct {
        int frames;
        int wen;
        int wrst;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    int         checks = 0;
    int         failures = 0;
    int         per = 800;
    int         pw = 20;
    int         hold = 50;
    bit         ven = 1'b0;
    int         wen_run = 0;
    int         wrst_run = 0;
    int         last_wen = 0;
    int         last_wrst = 0;
    logic       prev_nf = 1'b0;
    logic [7:0] exp_cnt = 8'd0;

    ov_capture_ctrl #(.VSYNC_TIMEOUT(24'd1000)) dut (
        .clk_24MHz       (clk_24MHz),
        .rst_n           (rst_n),
        .initialized     (initialized),
        .vsync           (vsync),
        .capture_req     (capture_req),
        .continuous      (continuous),
        .frame_read      (frame_read),
        .new_frame       (new_frame),
        .fifo_wen        (fifo_wen),
        .fifo_wrst_n     (fifo_wrst_n),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .frames_captured (frames_captured)
    );

    always #5 clk_24MHz = ~clk_24MHz;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_24MHz);
    endtask

    task automatic pulse_req();
        capture_req = 1'b1;
        tick(1);
        capture_req = 1'b0;
    endtask

    task automatic push_frame();
        exp_cnt++;
        q.push_back('{int'(exp_cnt), per - pw, pw});
    endtask

    task automatic wait_idle(input string name, input int lim);
        int n = 0;
        while ((busy || q.size() != 0) && n < lim) begin
            tick(1);
            n++;
        end
        chk(name, int'(n < lim), 1);
    endtask

    task automatic wait_wen(input string name);
        int n = 0;
        while (!fifo_wen && n < 3000) begin
            tick(1);
            n++;
        end
        chk(name, int'(fifo_wen), 1);
    endtask

    task automatic wait_nf(input string name);
        int n = 0;
        while (!new_frame && n < 3000) begin
            tick(1);
            n++;
        end
        chk(name, int'(new_frame), 1);
    endtask

    initial forever begin
        if (ven) begin
            vsync = 1'b1;
            repeat (pw) @(negedge clk_24MHz);
            vsync = 1'b0;
            repeat (per - pw) @(negedge clk_24MHz);
        end else begin
            vsync = 1'b0;
            @(negedge clk_24MHz);
        end
    end

    initial forever begin
        @(negedge clk_24MHz);
        if (new_frame && frame_read) begin
            repeat (2) @(negedge clk_24MHz);
            frame_read = 1'b0;
            repeat (hold) @(negedge clk_24MHz);
            frame_read = 1'b1;
        end
    end

    always @(negedge clk_24MHz) begin
        if (!rst_n) begin
            wen_run  = 0;
            wrst_run = 0;
            prev_nf  = 1'b0;
        end else begin
            if (fifo_wen) chk("wen_excl", int'({frame_read, fifo_wrst_n}), 3);
            if (fifo_wen) wen_run++;
            else if (wen_run != 0) begin
                last_wen = wen_run;
                wen_run  = 0;
            end
            if (!fifo_wrst_n) wrst_run++;
            else if (wrst_run != 0) begin
                last_wrst = wrst_run;
                wrst_run  = 0;
            end
            if (new_frame && !prev_nf) begin
                if (q.size() == 0) chk("unexpected_frame", 1, 0);
                else begin
                    me = q.pop_front();
                    chk("frames", int'(frames_captured), me.frames);
                    chk("wen_len", last_wen, me.wen);
                    chk("wrst_len", last_wrst, me.wrst);
                end
            end
            prev_nf = new_frame;
        end
    end

    initial begin
        int n;
        tick(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_new_frame", int'(new_frame), 0);
        chk("rst_wen", int'(fifo_wen), 0);
        chk("rst_wrst_n", int'(fifo_wrst_n), 1);
        chk("rst_timeout", int'(timeout_err), 0);
        chk("rst_frames", int'(frames_captured), 0);
        rst_n = 1'b1;
        initialized = 1'b1;
        ven = 1'b1;
        tick(5);

        push_frame();
        pulse_req();
        wait_idle("single_done", 4000);
        chk("single_frames", int'(frames_captured), 1);
        chk("single_idle", int'(busy), 0);

        repeat (3) push_frame();
        continuous = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 8000) begin
            tick(1);
            n++;
        end
        continuous = 1'b0;
        wait_idle("cont_done", 4000);
        chk("cont_frames", int'(frames_captured), 4);

        ven = 1'b0;
        tick(900);
        pulse_req();
        n = 0;
        while (busy && n < 5000) begin
            n++;
            tick(1);
        end
        chk("timeout_arm_cycles", n, 1000);
        chk("timeout_err_set", int'(timeout_err), 1);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_frames", int'(frames_captured), 4);
        ven = 1'b1;
        push_frame();
        pulse_req();
        tick(2);
        chk("timeout_cleared", int'(timeout_err), 0);
        wait_idle("timeout_next_done", 4000);
        chk("timeout_next_frames", int'(frames_captured), 5);

        push_frame();
        push_frame();
        pulse_req();
        wait_wen("pending_wen");
        tick(10);
        pulse_req();
        wait_nf("pending_nf");
        pulse_req();
        wait_idle("pending_done", 8000);
        tick(20);
        chk("pending_frames", int'(frames_captured), 7);
        chk("pending_dropped", int'(busy), 0);

        pulse_req();
        wait_wen("abort_wen_on");
        tick(100);
        initialized = 1'b0;
        capture_req = 1'b1;
        tick(1);
        capture_req = 1'b0;
        chk("abort_wen", int'(fifo_wen), 0);
        chk("abort_idle", int'(busy), 0);
        chk("abort_wrst_n", int'(fifo_wrst_n), 1);
        chk("abort_new_frame", int'(new_frame), 0);
        chk("abort_frames", int'(frames_captured), 7);
        initialized = 1'b1;
        push_frame();
        wait_idle("abort_pending_done", 4000);
        chk("abort_pending_frames", int'(frames_captured), 8);

        pulse_req();
        wait_wen("rst_mid_wen_on");
        tick(50);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_wen", int'(fifo_wen), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_frames", int'(frames_captured), 0);
        chk("rst_async_wrst_n", int'(fifo_wrst_n), 1);
        tick(2);
        rst_n = 1'b1;
        exp_cnt = 8'd0;

        per = 40;
        pw = 5;
        hold = 2;
        tick(900);
        repeat (256) push_frame();
        continuous = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 60000) begin
            tick(1);
            n++;
        end
        continuous = 1'b0;
        wait_idle("wrap_done", 2000);
        chk("wrap_frames", int'(frames_captured), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
